// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared mode encodings, bar colour table and default 640x480@60 timing
package video_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int NUM_BARS = 8;

    // {R,G,B} channel on/off per bar, left to right: white .. black
    localparam logic [2:0] BAR_TABLE [NUM_BARS] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [2:0] bar_color(input logic [3:0] idx);
        if (idx < 4'(NUM_BARS)) begin
            return BAR_TABLE[idx[2:0]];
        end
        return 3'b000;
    endfunction

endpackage

// File: rtl/video_pattern.sv
// rtl/video_pattern.sv - combinational test-pattern source selected by the frame-latched mode
module video_pattern
    import video_pkg::*;
#(
    parameter int HW          = 10,
    parameter int VW          = 10,
    parameter int COLOR_BITS  = 8,
    parameter int CHECK_SHIFT = 5
) (
    input  logic [HW-1:0]           h_i,
    input  logic [VW-1:0]           v_i,
    input  logic [3:0]              bar_idx_i,
    input  mode_e                   mode_i,
    input  logic [3*COLOR_BITS-1:0] solid_rgb_i,
    output logic [3*COLOR_BITS-1:0] rgb_o
);

    logic [2:0]            bar_on;
    logic                  check_on;
    logic [COLOR_BITS-1:0] ramp;

    assign bar_on = bar_color(bar_idx_i);
    // Shifting rather than bit-selecting keeps small rasters legal when CHECK_SHIFT exceeds the counter width
    assign check_on = 1'(h_i >> CHECK_SHIFT) ^ 1'(v_i >> CHECK_SHIFT);
    assign ramp     = COLOR_BITS'(h_i);

    always_comb begin
        rgb_o = '0;
        case (mode_i)
            MODE_SOLID: rgb_o = solid_rgb_i;
            MODE_BARS:  rgb_o = {{COLOR_BITS{bar_on[2]}}, {COLOR_BITS{bar_on[1]}}, {COLOR_BITS{bar_on[0]}}};
            MODE_CHECK: rgb_o = {(3*COLOR_BITS){check_on}};
            MODE_RAMP:  rgb_o = {ramp, ramp, ramp};
            default:    rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster counters, syncs, pattern mux and registered HDMI outputs
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int COLOR_BITS  = 8,
    parameter int CHECK_SHIFT = 5,
    parameter int FRAME_W     = 16
) (
    input  logic                    clock_25,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic                    data_enable,
    output logic                    horz_sync,
    output logic                    vert_sync,
    output logic [COLOR_BITS-1:0]   red,
    output logic [COLOR_BITS-1:0]   green,
    output logic [COLOR_BITS-1:0]   blue,
    output logic                    frame_start,
    output logic [FRAME_W-1:0]      frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int BW       = H_ACTIVE / NUM_BARS;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] BW_LAST = HW'(BW - 1);

    if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0 || H_ACTIVE < 8) begin : g_bad_params
        $error("video_timing_gen: invalid timing parameters");
    end

    logic [HW-1:0]           h_q, h_d, bar_cnt_q, bar_cnt_d;
    logic [VW-1:0]           v_q, v_d;
    logic [3:0]              bar_idx_q, bar_idx_d;
    mode_e                   active_mode_q, active_mode_d, pat_mode;
    logic                    de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d, pat_rgb;
    logic [FRAME_W-1:0]      fc_q, fc_d;
    logic                    at_origin, h_wrap, in_active, hs_win, vs_win;

    assign at_origin = (h_q == '0) && (v_q == '0);
    assign h_wrap    = (h_q == H_LAST);
    assign in_active = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign hs_win    = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    assign vs_win    = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
    // Pixel (0,0) already uses the freshly sampled mode so a new pattern starts exactly on the frame boundary
    assign pat_mode  = at_origin ? mode_e'(mode) : active_mode_q;

    video_pattern #(
        .HW          (HW),
        .VW          (VW),
        .COLOR_BITS  (COLOR_BITS),
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_pattern (
        .h_i         (h_q),
        .v_i         (v_q),
        .bar_idx_i   (bar_idx_q),
        .mode_i      (pat_mode),
        .solid_rgb_i (solid_rgb),
        .rgb_o       (pat_rgb)
    );

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        bar_cnt_d     = bar_cnt_q;
        bar_idx_d     = bar_idx_q;
        active_mode_d = active_mode_q;
        if (!enable) begin
            h_d       = '0;
            v_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else begin
            if (at_origin) begin
                active_mode_d = mode_e'(mode);
            end
            if (h_wrap) begin
                h_d       = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                v_d       = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                // Index saturates at NUM_BARS so leftover pixels past the last full bar stay black
                if (bar_idx_q < 4'(NUM_BARS)) begin
                    if (bar_cnt_q == BW_LAST) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 1'b1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        de_d  = 1'b0;
        hs_d  = ~HS_POL;
        vs_d  = ~VS_POL;
        fs_d  = 1'b0;
        rgb_d = '0;
        fc_d  = fc_q;
        if (enable) begin
            de_d  = in_active;
            hs_d  = hs_win ? HS_POL : ~HS_POL;
            vs_d  = vs_win ? VS_POL : ~VS_POL;
            fs_d  = at_origin;
            rgb_d = in_active ? pat_rgb : '0;
            if (at_origin) begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            h_q           <= '0;
            v_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            active_mode_q <= MODE_SOLID;
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            fs_q          <= 1'b0;
            rgb_q         <= '0;
            fc_q          <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            active_mode_q <= active_mode_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            fs_q          <= fs_d;
            rgb_q         <= rgb_d;
            fc_q          <= fc_d;
        end
    end

    assign data_enable = de_q;
    assign horz_sync   = hs_q;
    assign vert_sync   = vs_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
    assign red         = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign green       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
    assign blue        = rgb_q[COLOR_BITS-1:0];

endmodule
